// File: rtl/netwalk_match_resolver.sv
// Serialises a multi-hit match vector into one-hot grants, lowest bit first,
// with valid/ready handshakes on both sides plus match count and empty-match reporting.
module netwalk_match_resolver #(
   parameter int ENCODER_OUT_WIDTH = 6,
   parameter int MATCH_WIDTH       = 1 << ENCODER_OUT_WIDTH,
   parameter int COUNT_WIDTH       = ENCODER_OUT_WIDTH + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [MATCH_WIDTH-1:0] match_in,
   input  logic                   match_valid,
   output logic                   match_ready,
   output logic [MATCH_WIDTH-1:0] grant_out,
   output logic                   grant_valid,
   input  logic                   grant_ready,
   output logic                   grant_last,
   output logic [COUNT_WIDTH-1:0] grant_seq,
   output logic [COUNT_WIDTH-1:0] match_count,
   output logic                   no_match
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam logic [MATCH_WIDTH-1:0] ONE_M = {{(MATCH_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] ONE_C = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_r;
   logic [MATCH_WIDTH-1:0] pending_r;
   logic [MATCH_WIDTH-1:0] grant_out_r;
   logic                   grant_valid_r;
   logic                   grant_last_r;
   logic [COUNT_WIDTH-1:0] grant_seq_r;
   logic [COUNT_WIDTH-1:0] match_count_r;
   logic                   no_match_r;
   logic [MATCH_WIDTH-1:0] remain_s;
   logic                   match_ready_s;
   logic                   accept_s;

   function automatic logic [MATCH_WIDTH-1:0] lowest_bit(input logic [MATCH_WIDTH-1:0] v);
      return v & (~v + ONE_M);
   endfunction

   function automatic logic single_bit(input logic [MATCH_WIDTH-1:0] v);
      return ((v & (v - ONE_M)) == {MATCH_WIDTH{1'b0}});
   endfunction

   function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [MATCH_WIDTH-1:0] v);
      logic [COUNT_WIDTH-1:0] cnt;
      cnt = {COUNT_WIDTH{1'b0}};
      for (int i = 0; i < MATCH_WIDTH; i++) begin
         cnt = cnt + {{(COUNT_WIDTH-1){1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   // Ready decode: the last grant being consumed frees the slot in the same cycle
   always_comb begin
      match_ready_s = 1'b0;
      case (state_r)
         IDLE:    match_ready_s = 1'b1;
         ISSUE:   match_ready_s = grant_ready & grant_last_r;
         default: match_ready_s = 1'b0;
      endcase
      accept_s = match_valid & match_ready_s;
      remain_s = pending_r & ~grant_out_r;
   end

   // Issue FSM; grant outputs are precomputed from the next pending value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         pending_r     <= {MATCH_WIDTH{1'b0}};
         grant_out_r   <= {MATCH_WIDTH{1'b0}};
         grant_valid_r <= 1'b0;
         grant_last_r  <= 1'b0;
         grant_seq_r   <= {COUNT_WIDTH{1'b0}};
         match_count_r <= {COUNT_WIDTH{1'b0}};
         no_match_r    <= 1'b0;
      end else begin
         no_match_r <= 1'b0;
         case (state_r)
            IDLE, ISSUE: begin
               if (accept_s) begin
                  if (match_in == {MATCH_WIDTH{1'b0}}) begin
                     no_match_r    <= 1'b1;
                     state_r       <= IDLE;
                     pending_r     <= {MATCH_WIDTH{1'b0}};
                     grant_out_r   <= {MATCH_WIDTH{1'b0}};
                     grant_valid_r <= 1'b0;
                     grant_last_r  <= 1'b0;
                  end else begin
                     state_r       <= ISSUE;
                     pending_r     <= match_in;
                     grant_out_r   <= lowest_bit(match_in);
                     grant_valid_r <= 1'b1;
                     grant_last_r  <= single_bit(match_in);
                     grant_seq_r   <= {COUNT_WIDTH{1'b0}};
                     match_count_r <= popcount(match_in);
                  end
               end else if (state_r == ISSUE && grant_ready) begin
                  if (grant_last_r) begin
                     state_r       <= IDLE;
                     pending_r     <= {MATCH_WIDTH{1'b0}};
                     grant_out_r   <= {MATCH_WIDTH{1'b0}};
                     grant_valid_r <= 1'b0;
                     grant_last_r  <= 1'b0;
                  end else begin
                     pending_r    <= remain_s;
                     grant_out_r  <= lowest_bit(remain_s);
                     grant_last_r <= single_bit(remain_s);
                     grant_seq_r  <= grant_seq_r + ONE_C;
                  end
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r       <= IDLE;
               pending_r     <= {MATCH_WIDTH{1'b0}};
               grant_out_r   <= {MATCH_WIDTH{1'b0}};
               grant_valid_r <= 1'b0;
               grant_last_r  <= 1'b0;
            end
         endcase
      end
   end

   assign match_ready = match_ready_s;
   assign grant_out   = grant_out_r;
   assign grant_valid = grant_valid_r;
   assign grant_last  = grant_last_r;
   assign grant_seq   = grant_seq_r;
   assign match_count = match_count_r;
   assign no_match    = no_match_r;

endmodule

// File: tb/tb_netwalk_match_resolver.sv
// Directed self-checking bench for netwalk_match_resolver.
module tb_netwalk_match_resolver;

   logic        clk;
   logic        reset;
   logic [63:0] match_in;
   logic        match_valid;
   logic        match_ready;
   logic [63:0] grant_out;
   logic        grant_valid;
   logic        grant_ready;
   logic        grant_last;
   logic [6:0]  grant_seq;
   logic [6:0]  match_count;
   logic        no_match;

   int tests_run;
   int tests_failed;

   netwalk_match_resolver dut (
      .clk         (clk),
      .reset       (reset),
      .match_in    (match_in),
      .match_valid (match_valid),
      .match_ready (match_ready),
      .grant_out   (grant_out),
      .grant_valid (grant_valid),
      .grant_ready (grant_ready),
      .grant_last  (grant_last),
      .grant_seq   (grant_seq),
      .match_count (match_count),
      .no_match    (no_match)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] vec);
      match_in    = vec;
      match_valid = 1'b1;
      cyc();
      match_valid = 1'b0;
      #1;
   endtask

   task automatic check_grant(input string tag, input logic [63:0] g, input int seq,
                              input logic last, input int cnt);
      check({tag, ".out"},   grant_out, g);
      check({tag, ".valid"}, 64'(grant_valid), 64'd1);
      check({tag, ".seq"},   64'(grant_seq), 64'(seq));
      check({tag, ".last"},  64'(grant_last), 64'(last));
      check({tag, ".count"}, 64'(match_count), 64'(cnt));
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".valid"}, 64'(grant_valid), 64'd0);
      check({tag, ".out"},   grant_out, 64'd0);
      check({tag, ".ready"}, 64'(match_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] exp_g;
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      match_in     = 64'd0;
      match_valid  = 1'b0;
      grant_ready  = 1'b1;
      #2;
      check_idle("rst");
      check("rst.count", 64'(match_count), 64'd0);
      check("rst.seq", 64'(grant_seq), 64'd0);
      check("rst.nomatch", 64'(no_match), 64'd0);
      check("rst.last", 64'(grant_last), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      cyc();

      // Test 1: single bit vector
      send(64'h1);
      check_grant("t1", 64'h1, 0, 1'b1, 1);
      cyc();
      check_idle("t1.after");
      check("t1.count_hold", 64'(match_count), 64'd1);

      // Test 2: three grants, no backpressure
      send(64'h8000_0000_0000_0009);
      check_grant("t2.g0", 64'h1, 0, 1'b0, 3);
      cyc();
      check_grant("t2.g1", 64'h8, 1, 1'b0, 3);
      cyc();
      check_grant("t2.g2", 64'h8000_0000_0000_0000, 2, 1'b1, 3);
      cyc();
      check_idle("t2.after");

      // Test 3: backpressure holds the first grant
      grant_ready = 1'b0;
      send(64'h8000_0000_0000_0009);
      check_grant("t3.g0", 64'h1, 0, 1'b0, 3);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("t3.hold.out", grant_out, 64'h1);
         check("t3.hold.seq", 64'(grant_seq), 64'd0);
         check("t3.hold.ready", 64'(match_ready), 64'd0);
      end
      grant_ready = 1'b1;
      cyc();
      check_grant("t3.g1", 64'h8, 1, 1'b0, 3);
      cyc();
      check_grant("t3.g2", 64'h8000_0000_0000_0000, 2, 1'b1, 3);
      cyc();
      check_idle("t3.after");

      // Test 4: zero vector
      send(64'h0);
      check("t4.nomatch", 64'(no_match), 64'd1);
      check_idle("t4");
      cyc();
      check("t4.nomatch_clr", 64'(no_match), 64'd0);
      check_idle("t4.after");

      // Test 5: back-to-back vector on last grant
      send(64'h3);
      check_grant("t5.g0", 64'h1, 0, 1'b0, 2);
      match_in    = 64'h4;
      match_valid = 1'b1;
      #1;
      check("t5.notready", 64'(match_ready), 64'd0);
      cyc();
      check_grant("t5.g1", 64'h2, 1, 1'b1, 2);
      check("t5.ready", 64'(match_ready), 64'd1);
      cyc();
      match_valid = 1'b0;
      check_grant("t5.new", 64'h4, 0, 1'b1, 1);
      cyc();
      check_idle("t5.after");

      // Test 6: all-ones interrupted by async reset
      send({64{1'b1}});
      check_grant("t6.g0", 64'h1, 0, 1'b0, 64);
      for (int i = 0; i < 10; i++) cyc();
      check("t6.g10", grant_out, 64'h400);
      #2;
      reset = 1'b0;
      #1;
      check("t6.rst.valid", 64'(grant_valid), 64'd0);
      check("t6.rst.out", grant_out, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t6.rst.ready", 64'(match_ready), 64'd1);
      check("t6.rst.count", 64'(match_count), 64'd0);
      cyc();

      // Full all-ones run
      send({64{1'b1}});
      for (int i = 0; i < 64; i++) begin
         exp_g = 64'h1 << i;
         check_grant("t6.full", exp_g, i, (i == 63), 64);
         cyc();
      end
      check_idle("t6.full.after");
      check("t6.full.count_hold", 64'(match_count), 64'd64);
      check("t6.full.seq_hold", 64'(grant_seq), 64'd63);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
